coax_transaction_controller: RTL and testbench

// Sequences one coax command/response transaction over coax_buffered_tx and coax_buffered_rx.
// The host preloads the TX FIFO and pulses start; this block then:
// - fires the TX start strobe and supervises transmission;
// - flushes stale RX state and waits a bounded time for the device response;
// - reports a single status code.

---
 rtl/coax_transaction_controller.sv | 156 +++++++++++++++
 tb/tb_coax_transaction_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_transaction_controller.sv
// Sequences one coax command/response transaction: start strobe, TX supervision, bounded RX wait, status report.
// Optional response-latency register is built only when COAX_TXN_LATENCY_EN is defined.
module coax_transaction_controller #(
    parameter int START_TIMEOUT_CLOCKS    = 64,
    parameter int RESPONSE_TIMEOUT_CLOCKS = 1024,
    parameter bit FLUSH_RX                = 1'b1,
    parameter int CNT_WIDTH               = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 tx_active,
    input  logic                 tx_empty,
    input  logic                 rx_active,
    input  logic                 rx_error,
    output logic                 tx_start_strobe,
    output logic                 rx_reset,
    output logic                 busy,
    output logic                 done_strobe,
    output logic [2:0]           status,
    output logic [CNT_WIDTH-1:0] response_latency
);

    typedef enum logic [2:0] {
        IDLE, START, TX_WAIT, TX_BUSY, RX_WAIT, RX_BUSY, DONE
    } state_t;

    localparam logic [2:0] ST_OK          = 3'd0;
    localparam logic [2:0] ST_NO_RESPONSE = 3'd1;
    localparam logic [2:0] ST_RX_ERROR    = 3'd2;
    localparam logic [2:0] ST_TX_FAULT    = 3'd3;
    localparam logic [2:0] ST_ABORTED     = 3'd4;

    localparam logic [CNT_WIDTH-1:0] START_LAST = CNT_WIDTH'(START_TIMEOUT_CLOCKS - 1);
    localparam logic [CNT_WIDTH-1:0] RESP_LAST  = CNT_WIDTH'(RESPONSE_TIMEOUT_CLOCKS - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 in_txn;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
    assign in_txn  = (state == START) || (state == TX_WAIT) || (state == TX_BUSY) ||
                     (state == RX_WAIT) || (state == RX_BUSY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            tx_start_strobe <= 1'b0;
            rx_reset        <= 1'b0;
            busy            <= 1'b0;
            done_strobe     <= 1'b0;
            status          <= ST_OK;
        end else begin
            tx_start_strobe <= 1'b0;
            rx_reset        <= 1'b0;
            done_strobe     <= 1'b0;
            // abort pre-empts whatever the current state would have done this cycle
            if (in_txn && abort) begin
                state       <= DONE;
                status      <= ST_ABORTED;
                busy        <= 1'b0;
                done_strobe <= 1'b1;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            if (tx_empty) begin
                                state       <= DONE;
                                status      <= ST_TX_FAULT;
                                done_strobe <= 1'b1;
                            end else begin
                                state           <= START;
                                status          <= ST_OK;
                                busy            <= 1'b1;
                                tx_start_strobe <= 1'b1;
                                rx_reset        <= FLUSH_RX;
                            end
                        end
                    end
                    START: begin
                        cnt   <= '0;
                        state <= TX_WAIT;
                    end
                    TX_WAIT: begin
                        if (tx_active) begin
                            state <= TX_BUSY;
                        end else if (cnt == START_LAST) begin
                            state       <= DONE;
                            status      <= ST_TX_FAULT;
                            busy        <= 1'b0;
                            done_strobe <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    TX_BUSY: begin
                        if (!tx_active) begin
                            cnt   <= '0;
                            state <= RX_WAIT;
                        end
                    end
                    RX_WAIT: begin
                        cnt <= cnt_inc;
                        if (rx_error) begin
                            state       <= DONE;
                            status      <= ST_RX_ERROR;
                            busy        <= 1'b0;
                            done_strobe <= 1'b1;
                        end else if (rx_active) begin
                            state <= RX_BUSY;
                        end else if (cnt == RESP_LAST) begin
                            state       <= DONE;
                            status      <= ST_NO_RESPONSE;
                            busy        <= 1'b0;
                            done_strobe <= 1'b1;
                        end
                    end
                    RX_BUSY: begin
                        if (rx_error || !rx_active) begin
                            state       <= DONE;
                            status      <= rx_error ? ST_RX_ERROR : ST_OK;
                            busy        <= 1'b0;
                            done_strobe <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef COAX_TXN_LATENCY_EN
    logic accept;
    assign accept = ((state == IDLE) || (state == DONE)) && start;

    // Latched value counts the capture cycle itself, i.e. clocks from TX fall to RX rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            response_latency <= '0;
        end else if (accept || (in_txn && abort)) begin
            response_latency <= '0;
        end else if ((state == RX_WAIT) && !rx_error && rx_active) begin
            response_latency <= cnt_inc;
        end
    end
`else
    assign response_latency = '0;
`endif

endmodule

// File: tb/tb_coax_transaction_controller.sv
// Self-checking bench for coax_transaction_controller: directed corner cases plus randomized transactions
// scored against a scenario-level reference model.
module tb_coax_transaction_controller;

    localparam int START_TO = 64;
    localparam int RESP_TO  = 1024;
    localparam int CW       = 16;
`ifdef COAX_TXN_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tx_active = 1'b0;
    logic          tx_empty = 1'b0;
    logic          rx_active = 1'b0;
    logic          rx_error = 1'b0;
    logic          tx_start_strobe;
    logic          rx_reset;
    logic          busy;
    logic          done_strobe;
    logic [2:0]    status;
    logic [CW-1:0] response_latency;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_rxr = 0;
    int n_done = 0;
    int done_cyc = 0;
    int strobe_cyc = 0;

    coax_transaction_controller #(
        .START_TIMEOUT_CLOCKS   (START_TO),
        .RESPONSE_TIMEOUT_CLOCKS(RESP_TO),
        .FLUSH_RX               (1'b1),
        .CNT_WIDTH              (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .tx_active       (tx_active),
        .tx_empty        (tx_empty),
        .rx_active       (rx_active),
        .rx_error        (rx_error),
        .tx_start_strobe (tx_start_strobe),
        .rx_reset        (rx_reset),
        .busy            (busy),
        .done_strobe     (done_strobe),
        .status          (status),
        .response_latency(response_latency)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (tx_start_strobe) begin
            n_strobe   <= n_strobe + 1;
            strobe_cyc <= cyc;
        end
        if (rx_reset) n_rxr <= n_rxr + 1;
        if (done_strobe) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full transaction. rx_delay: clocks from TX fall to the RX event (0 = device never answers).
    // err_mode: 0 clean, 1 rx_error together with rx_active falling, 2 rx_error instead of a response.
    task automatic run_txn(input string name, input int tx_delay, input int tx_len,
                           input int rx_delay, input int rx_len, input int err_mode);
        int s0, r0, d0, fall, exp_st, exp_lat, exp_off;
        s0 = n_strobe;
        r0 = n_rxr;
        d0 = n_done;
        if (err_mode == 2) begin
            exp_st = 2; exp_lat = 0; exp_off = rx_delay;
        end else if (rx_delay == 0) begin
            exp_st = 1; exp_lat = 0; exp_off = RESP_TO;
        end else begin
            exp_st  = (err_mode == 1) ? 2 : 0;
            exp_lat = rx_delay;
            exp_off = rx_delay + rx_len;
        end
        if (!LAT_EN) exp_lat = 0;

        tx_empty = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ".start_strobe"}, tx_start_strobe, 1);
        check({name, ".start_busy"}, busy, 1);
        check({name, ".start_status"}, status, 0);
        tick();
        tick(tx_delay);
        tx_active = 1'b1;
        tick();
        for (int i = 1; i < tx_len; i++) begin
            start = (i == 1);
            tick();
        end
        start = 1'b0;
        tx_active = 1'b0;
        tick();
        fall = cyc;
        if (err_mode == 2) begin
            tick(rx_delay - 1);
            rx_error = 1'b1;
            tick();
            rx_error = 1'b0;
        end else if (rx_delay > 0) begin
            tick(rx_delay - 1);
            rx_active = 1'b1;
            tick();
            tick(rx_len - 1);
            rx_active = 1'b0;
            rx_error = (err_mode == 1);
            tick();
            rx_error = 1'b0;
        end else begin
            for (int i = 0; i < RESP_TO + 100 && n_done == d0; i++) tick();
        end
        tick(2);
        check({name, ".done_count"}, n_done - d0, 1);
        check({name, ".strobe_count"}, n_strobe - s0, 1);
        check({name, ".rx_reset_count"}, n_rxr - r0, 1);
        check({name, ".status"}, status, exp_st);
        check({name, ".latency"}, response_latency, exp_lat);
        check({name, ".done_time"}, done_cyc - fall, exp_off);
        check({name, ".busy_after"}, busy, 0);
        $display("txn %s tx_delay=%0d tx_len=%0d rx_delay=%0d rx_len=%0d err=%0d status=%0d latency=%0d",
                 name, tx_delay, tx_len, rx_delay, rx_len, err_mode, status, response_latency);
    endtask

    initial begin
        int s0, d0, td, tl, rd, rl, em;

        // reset state
        tick(3);
        check("reset.tx_start_strobe", tx_start_strobe, 0);
        check("reset.rx_reset", rx_reset, 0);
        check("reset.busy", busy, 0);
        check("reset.done_strobe", done_strobe, 0);
        check("reset.status", status, 0);
        check("reset.latency", response_latency, 0);
        reset_n = 1'b1;
        tick(2);

        // nominal transaction, boundary response on the final count, error priority, silent device
        run_txn("normal", 2, 38, 100, 50, 0);
        run_txn("last_count", 0, 5, RESP_TO, 4, 0);
        run_txn("err_priority", 1, 6, 30, 10, 1);
        run_txn("no_response", 3, 4, 0, 1, 0);

        // start with an empty TX FIFO: fault without any strobe
        s0 = n_strobe;
        d0 = n_done;
        tx_empty = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tx_empty = 1'b0;
        tick(2);
        check("empty.status", status, 3);
        check("empty.strobe_count", n_strobe - s0, 0);
        check("empty.done_count", n_done - d0, 1);
        check("empty.latency", response_latency, 0);
        $display("txn empty_fifo status=%0d", status);

        // tx_active never rises: fault after the START cycle plus the full TX_WAIT allowance
        d0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && n_done == d0; i++) tick();
        tick();
        check("tx_timeout.done_count", n_done - d0, 1);
        check("tx_timeout.status", status, 3);
        check("tx_timeout.done_time", done_cyc - strobe_cyc, 1 + START_TO);
        $display("txn tx_timeout status=%0d", status);

        // abort during TX_BUSY
        d0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        tx_active = 1'b1;
        tick(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tx_active = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.done_strobe", done_strobe, 1);
        check("abort.status", status, 4);
        check("abort.latency", response_latency, 0);
        tick(2);
        check("abort.done_count", n_done - d0, 1);
        // abort while already DONE is ignored
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        tick();
        check("abort_idle.done_count", n_done - d0, 1);
        check("abort_idle.status", status, 4);
        $display("txn abort status=%0d", status);

        // asynchronous reset in the middle of RX_WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        tx_active = 1'b1;
        tick(3);
        tx_active = 1'b0;
        tick(10);
        check("pre_reset.busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset.busy", busy, 0);
        check("async_reset.status", status, 0);
        check("async_reset.strobes", {tx_start_strobe, rx_reset, done_strobe}, 0);
        check("async_reset.latency", response_latency, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        $display("txn async_reset busy=%0d status=%0d", busy, status);

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            td = $urandom_range(0, 20);
            tl = $urandom_range(1, 30);
            rd = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, RESP_TO);
            rl = $urandom_range(1, 20);
            em = $urandom_range(0, 2);
            if (rd == 0 && em == 2) em = 0;
            run_txn($sformatf("rand%0d", t), td, tl, rd, rl, em);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
